// File: rtl/mips_imem_loader.sv
// Loads a length-prefixed stream of big-endian words into instruction memory and holds the CPU in reset while it does.
// Define IMEM_LOADER_CHECKSUM_EN to add an XOR trailer byte check over the payload bytes.
module mips_imem_loader #(
    parameter int          MAX_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [10:0] word_count
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        RECV   = 3'd3,
        WRITE  = 3'd4,
        FIN    = 3'd5,
        DONE   = 3'd6
`ifdef IMEM_LOADER_CHECKSUM_EN
        , CHK  = 3'd7
`endif
    } state_t;

    state_t      state;
    logic [15:0] len;
    logic [1:0]  idx;
    logic [23:0] acc;
    logic        xfer;
    logic [15:0] len_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  chk;
`endif

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign byte_ready = (state == LEN_HI) || (state == LEN_LO) || (state == RECV) || (state == CHK);
`else
    assign byte_ready = (state == LEN_HI) || (state == LEN_LO) || (state == RECV);
`endif
    assign xfer     = byte_valid && byte_ready;
    assign len_next = {len[15:8], byte_data};
    assign cpu_hold = busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len        <= '0;
            idx        <= '0;
            acc        <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk        <= '0;
`endif
        end else begin
            case (state)
                // DONE behaves like IDLE except that done/err stay visible until the next start
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LEN_HI;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        word_count <= '0;
                        idx        <= '0;
                        len        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk        <= '0;
`endif
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= byte_data;
                        state     <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= byte_data;
                        if (len_next == 16'd0) begin
                            state <= FIN;
                        end else if (len_next > 16'(MAX_WORDS)) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            state <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (xfer) begin
                        acc <= {acc[15:0], byte_data};
                        idx <= idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk <= chk ^ byte_data;
`endif
                        if (idx == 2'd3) begin
                            wr_en   <= 1'b1;
                            wr_data <= {acc, byte_data};
                            wr_addr <= BASE_ADDR + {19'd0, word_count, 2'b00};
                            state   <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    wr_en      <= 1'b0;
                    word_count <= word_count + 11'd1;
                    if (({5'd0, word_count} + 16'd1) == len)
                        state <= FIN;
                    else
                        state <= RECV;
                end
                FIN: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state <= CHK;
`else
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
`endif
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                // Words are already in memory; a bad trailer only flags the load
                CHK: begin
                    if (xfer) begin
                        if (byte_data != chk)
                            err <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_imem_loader.sv
// Directed bench for mips_imem_loader: frame loads, stalls, length error, zero length, restart, reset mid-load.
`timescale 1ns/1ps
module tb_mips_imem_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [10:0] word_count;

    int errors = 0;
    int checks = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int rdy_viol = 0;

    mips_imem_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .cpu_hold(cpu_hold), .done(done), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Capture memory writes away from the active edge
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            if (byte_ready) rdy_viol++;
        end
    end

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        rdy_viol = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            errors++;
            checks++;
            $display("FAIL send_byte timeout: byte_ready=%b required 1", byte_ready);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s wait_done: done=%b required 1", name, done);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, cpu_hold, done, err, byte_ready, wr_en, word_count, wr_addr, wr_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b err=%b rdy=%b wr_en=%b wc=%0d required all 0",
                     busy, done, err, byte_ready, wr_en, word_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b rdy=%b required 0 0", busy, byte_ready);
        end
    endtask

    task automatic test_basic();
        clear_log();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: busy=%b hold=%b done=%b required 1 1 0", busy, cpu_hold, done);
        end
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h24, 0); send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 32'h0 || wr_data !== 32'h24010001 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency: wr_en=%b addr=%h data=%h rdy=%b required 1 0 24010001 0",
                     wr_en, wr_addr, wr_data, byte_ready);
        end
        send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h11, 0); send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h34, 0);
`endif
        wait_done("basic");
        checks++;
        if (wa_q.size() != 2) begin
            errors++;
            $display("FAIL basic_nwrites: got %0d required 2", wa_q.size());
        end else if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'h24010001 ||
                     wa_q[1] !== 32'h4 || wd_q[1] !== 32'h00011100) begin
            errors++;
            $display("FAIL basic_writes: %h:%h %h:%h required 0:24010001 4:00011100",
                     wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
        end
        checks++;
        if (err !== 1'b0 || word_count !== 11'd2 || busy !== 1'b0 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL basic_status: err=%b wc=%0d busy=%b hold=%b required 0 2 0 0",
                     err, word_count, busy, cpu_hold);
        end
    endtask

    task automatic test_stall();
        logic [7:0] fr[10] = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h11, 8'h00};
        int gaps[10] = '{2, 0, 3, 1, 0, 4, 1, 0, 2, 3};
        clear_log();
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(fr[i], gaps[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h34, 2);
`endif
        wait_done("stall");
        checks++;
        if (wa_q.size() != 2) begin
            errors++;
            $display("FAIL stall_nwrites: got %0d required 2", wa_q.size());
        end else if (wd_q[0] !== 32'h24010001 || wd_q[1] !== 32'h00011100 || wa_q[1] !== 32'h4) begin
            errors++;
            $display("FAIL stall_writes: %h:%h %h:%h required 0:24010001 4:00011100",
                     wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
        end
        checks++;
        if (rdy_viol != 0 || err !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready_in_write: viol=%0d err=%b required 0 0", rdy_viol, err);
        end
    endtask

    task automatic test_start_busy();
        clear_log();
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h24, 0); send_byte(8'h01, 0);
        pulse_start();
        checks++;
        if (busy !== 1'b1 || byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL busy_start_ignored: busy=%b rdy=%b required 1 1", busy, byte_ready);
        end
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h11, 0); send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h34, 0);
`endif
        wait_done("start_busy");
        checks++;
        if (wa_q.size() != 2 || word_count !== 11'd2) begin
            errors++;
            $display("FAIL busy_start_writes: n=%0d wc=%0d required 2 2", wa_q.size(), word_count);
        end else if (wd_q[0] !== 32'h24010001 || wa_q[1] !== 32'h4 || wd_q[1] !== 32'h00011100) begin
            errors++;
            $display("FAIL busy_start_data: %h:%h %h:%h required 0:24010001 4:00011100",
                     wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
        end
    endtask

    task automatic test_len_err();
        int rdy_seen;
        rdy_seen = 0;
        clear_log();
        pulse_start();
        send_byte(8'h04, 0); send_byte(8'h01, 0);
        checks++;
        if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL len_err_status: done=%b err=%b busy=%b rdy=%b required 1 1 0 0",
                     done, err, busy, byte_ready);
        end
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (byte_ready) rdy_seen++;
        end
        byte_valid = 1'b0;
        checks++;
        if (rdy_seen != 0 || wa_q.size() != 0 || word_count !== 11'd0) begin
            errors++;
            $display("FAIL len_err_trailing: rdy_cycles=%0d writes=%0d wc=%0d required 0 0 0",
                     rdy_seen, wa_q.size(), word_count);
        end
    endtask

    task automatic test_zero_restart();
        clear_log();
        pulse_start();
        checks++;
        if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b1 || word_count !== 11'd0) begin
            errors++;
            $display("FAIL restart_clear: done=%b err=%b busy=%b wc=%0d required 0 0 1 0",
                     done, err, busy, word_count);
        end
        send_byte(8'h00, 0); send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        wait_done("zero_len");
        checks++;
        if (wa_q.size() != 0 || err !== 1'b0 || word_count !== 11'd0) begin
            errors++;
            $display("FAIL zero_len: writes=%0d err=%b wc=%0d required 0 0 0", wa_q.size(), err, word_count);
        end
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h22, 0);
`endif
        wait_done("reload");
        checks++;
        if (wa_q.size() != 1 || word_count !== 11'd1 || err !== 1'b0) begin
            errors++;
            $display("FAIL reload_count: writes=%0d wc=%0d err=%b required 1 1 0", wa_q.size(), word_count, err);
        end else if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL reload_write: %h:%h required 0:deadbeef", wa_q[0], wd_q[0]);
        end
    endtask

    task automatic test_reset_midload();
        clear_log();
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, cpu_hold, done, err, byte_ready, wr_en, word_count, wr_addr, wr_data} !== '0) begin
            errors++;
            $display("FAIL midload_reset: busy=%b done=%b rdy=%b wr_en=%b addr=%h data=%h required all 0",
                     busy, done, byte_ready, wr_en, wr_addr, wr_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h56;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || byte_ready !== 1'b0 || wa_q.size() != 0) begin
            errors++;
            $display("FAIL midload_idle: busy=%b rdy=%b writes=%0d required 0 0 0", busy, byte_ready, wa_q.size());
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] fr[10] = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h11, 8'h00};
        clear_log();
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(fr[i], 0);
        send_byte(8'h34, 0);
        wait_done("chk_good");
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL chk_good: err=%b required 0", err);
        end
        clear_log();
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(fr[i], 0);
        send_byte(8'h00, 0);
        wait_done("chk_bad");
        checks++;
        if (err !== 1'b1 || wa_q.size() != 2) begin
            errors++;
            $display("FAIL chk_bad: err=%b writes=%0d required 1 2", err, wa_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_start_busy();
        test_len_err();
        test_zero_restart();
        test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
